vec_exec_pipe: RTL and testbench

Parametrised vector execute-to-writeback pipeline. It is the successor to the fixed E/M/W vector path with 128-bit registers and hard-wired 3-input forwarding muxes.
- Carries LANES x LANE_W vector results through DEPTH pipeline stages, with per-stage valid, destination register, write-enable and lane mask.
- Provides a per-lane, youngest-first forwarding network for two source operands.
- Sits between the vector ALU / load-store result mux and regfile_vec. Driven by the existing hazard unit's stall and flush.

---
 rtl/vec_pipe_pkg.sv | 23 ++
 rtl/vec_fwd_lane.sv | 27 ++
 rtl/vec_exec_pipe.sv | 148 ++++++++++++++
 tb/tb_vec_exec_pipe.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/vec_pipe_pkg.sv
// Shared definitions for the vector execute-to-writeback pipeline: geometry defaults,
// the default-geometry stage record, and the saturating-counter helper.
package vec_pipe_pkg;

   localparam int LANES_DEF  = 8;
   localparam int LANE_W_DEF = 16;
   localparam int REG_W_DEF  = 5;

   localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

   typedef struct packed {
      logic                              valid;
      logic                              wen;
      logic [REG_W_DEF-1:0]              wreg;
      logic [LANES_DEF-1:0]              mask;
      logic [LANES_DEF*LANE_W_DEF-1:0]   data;
   } stage_t;

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == SAT_MAX) ? v : v + 32'd1;
   endfunction

endpackage

// File: rtl/vec_fwd_lane.sv
// One lane of the forwarding network: youngest-first (lowest stage index) select over
// DEPTH in-flight stages, falling back to the regfile value.
module vec_fwd_lane #(
   parameter int DEPTH  = 3,
   parameter int LANE_W = 16
) (
   input  logic [DEPTH-1:0]             cand_i,
   input  logic [DEPTH-1:0][LANE_W-1:0] data_i,
   input  logic [LANE_W-1:0]            rf_i,
   output logic [LANE_W-1:0]            data_o,
   output logic                         hit_o
);

   // NOTE: every output gets a default before the loop so no latch is inferred.
   always_comb begin
      data_o = rf_i;
      hit_o  = 1'b0;
      // Scan oldest to youngest so the youngest candidate is the last to override.
      for (int k = DEPTH-1; k >= 0; k--) begin
         if (cand_i[k]) begin
            data_o = data_i[k];
            hit_o  = 1'b1;
         end
      end
   end

endmodule

// File: rtl/vec_exec_pipe.sv
// Parametrised vector execute-to-writeback pipeline with per-lane forwarding.
// Optional macro VEC_PIPE_LANEMASK_EN stores per-stage lane masks; otherwise masks are all-ones.
module vec_exec_pipe
   import vec_pipe_pkg::*;
#(
   parameter int LANES  = LANES_DEF,
   parameter int LANE_W = LANE_W_DEF,
   parameter int DEPTH  = 3,
   parameter int REG_W  = REG_W_DEF
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        in_valid,
   input  logic                        in_wen,
   input  logic [REG_W-1:0]            in_wreg,
   input  logic [LANES*LANE_W-1:0]     in_data,
   input  logic [LANES-1:0]            in_mask,
   input  logic                        stall,
   input  logic                        flush,
   output logic                        in_ready,
   input  logic [REG_W-1:0]            rs_a,
   input  logic [REG_W-1:0]            rs_b,
   input  logic [LANES*LANE_W-1:0]     rf_a,
   input  logic [LANES*LANE_W-1:0]     rf_b,
   output logic [LANES*LANE_W-1:0]     fwd_a,
   output logic [LANES*LANE_W-1:0]     fwd_b,
   output logic [LANES-1:0]            fwd_hit_a,
   output logic [LANES-1:0]            fwd_hit_b,
   output logic                        wb_fire,
   output logic [REG_W-1:0]            wb_reg,
   output logic [LANES*LANE_W-1:0]     wb_data,
   output logic [LANES-1:0]            wb_mask,
   output logic [$clog2(DEPTH+1)-1:0]  occupancy,
   output logic [31:0]                 stall_cycles
);

   localparam int OCC_W = $clog2(DEPTH+1);

   typedef struct packed {
      logic                    valid;
      logic                    wen;
      logic [REG_W-1:0]        wreg;
`ifdef VEC_PIPE_LANEMASK_EN
      logic [LANES-1:0]        mask;
`endif
      logic [LANES*LANE_W-1:0] data;
   } pipe_stage_t;

   pipe_stage_t [DEPTH-1:0]        stage_q, stage_d;
   logic        [OCC_W-1:0]        occ_q, occ_d;
   logic        [31:0]             stall_cnt_q, stall_cnt_d;
   logic        [DEPTH-1:0]        match_a, match_b;
   logic        [DEPTH-1:0][LANES-1:0] lane_en;

   always_comb begin
      stage_d = stage_q;
      if (!stall) begin
         stage_d[0].valid = in_valid & ~flush;
         stage_d[0].wen   = in_wen;
         stage_d[0].wreg  = in_wreg;
`ifdef VEC_PIPE_LANEMASK_EN
         stage_d[0].mask  = in_mask;
`endif
         stage_d[0].data  = in_data;
         for (int k = 1; k < DEPTH; k++) stage_d[k] = stage_q[k-1];
      end else if (flush) begin
         // A flush under stall kills only the stage-0 entry, leaving a bubble.
         stage_d[0].valid = 1'b0;
      end
   end

   always_comb begin
      occ_d = '0;
      for (int k = 0; k < DEPTH; k++) occ_d = occ_d + OCC_W'(stage_d[k].valid);
      stall_cnt_d = (stall && (occ_q != '0)) ? sat_inc(stall_cnt_q) : stall_cnt_q;
   end

   // NOTE: state registers use non-blocking assignments so every stage samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         // NOTE: stage data is cleared as well, so writeback outputs read zero out of reset.
         stage_q     <= '0;
         occ_q       <= '0;
         stall_cnt_q <= '0;
      end else begin
         stage_q     <= stage_d;
         occ_q       <= occ_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         match_a[k] = stage_q[k].valid & stage_q[k].wen & (stage_q[k].wreg == rs_a);
         match_b[k] = stage_q[k].valid & stage_q[k].wen & (stage_q[k].wreg == rs_b);
`ifdef VEC_PIPE_LANEMASK_EN
         lane_en[k] = stage_q[k].mask;
`else
         lane_en[k] = '1;
`endif
      end
   end

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      logic [DEPTH-1:0]             cand_a, cand_b;
      logic [DEPTH-1:0][LANE_W-1:0] lane_data;

      always_comb begin
         for (int k = 0; k < DEPTH; k++) begin
            lane_data[k] = stage_q[k].data[i*LANE_W +: LANE_W];
            cand_a[k]    = match_a[k] & lane_en[k][i];
            cand_b[k]    = match_b[k] & lane_en[k][i];
         end
      end

      vec_fwd_lane #(.DEPTH(DEPTH), .LANE_W(LANE_W)) u_fwd_a (
         .cand_i (cand_a),
         .data_i (lane_data),
         .rf_i   (rf_a[i*LANE_W +: LANE_W]),
         .data_o (fwd_a[i*LANE_W +: LANE_W]),
         .hit_o  (fwd_hit_a[i])
      );

      vec_fwd_lane #(.DEPTH(DEPTH), .LANE_W(LANE_W)) u_fwd_b (
         .cand_i (cand_b),
         .data_i (lane_data),
         .rf_i   (rf_b[i*LANE_W +: LANE_W]),
         .data_o (fwd_b[i*LANE_W +: LANE_W]),
         .hit_o  (fwd_hit_b[i])
      );
   end

   assign in_ready     = ~stall;
   assign wb_fire      = stage_q[DEPTH-1].valid & stage_q[DEPTH-1].wen & ~stall;
   assign wb_reg       = stage_q[DEPTH-1].wreg;
   assign wb_data      = stage_q[DEPTH-1].data;
   assign occupancy    = occ_q;
   assign stall_cycles = stall_cnt_q;

`ifdef VEC_PIPE_LANEMASK_EN
   assign wb_mask = stage_q[DEPTH-1].mask;
`else
   assign wb_mask = '1;
   logic unused_mask;
   assign unused_mask = ^in_mask;
`endif

endmodule

// File: tb/tb_vec_exec_pipe.sv
// Self-checking bench for vec_exec_pipe (default geometry): writeback scoreboard plus
// directed forwarding, stall/flush and reset checks. Mask-dependent expectations follow VEC_PIPE_LANEMASK_EN.
module tb_vec_exec_pipe;
   import vec_pipe_pkg::*;

`ifdef VEC_PIPE_LANEMASK_EN
   localparam bit MASK_EN = 1'b1;
`else
   localparam bit MASK_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid, in_wen, stall, flush, in_ready;
   logic [4:0]   in_wreg, rs_a, rs_b, wb_reg;
   logic [127:0] in_data, rf_a, rf_b, fwd_a, fwd_b, wb_data;
   logic [7:0]   in_mask, fwd_hit_a, fwd_hit_b, wb_mask;
   logic         wb_fire;
   logic [1:0]   occupancy;
   logic [31:0]  stall_cycles;

   int n_tests = 0;
   int n_fail  = 0;
   stage_t exp_q[$];

   vec_exec_pipe #(.LANES(8), .LANE_W(16), .DEPTH(3), .REG_W(5)) dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_wen(in_wen), .in_wreg(in_wreg), .in_data(in_data), .in_mask(in_mask),
      .stall(stall), .flush(flush), .in_ready(in_ready),
      .rs_a(rs_a), .rs_b(rs_b), .rf_a(rf_a), .rf_b(rf_b),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_hit_a(fwd_hit_a), .fwd_hit_b(fwd_hit_b),
      .wb_fire(wb_fire), .wb_reg(wb_reg), .wb_data(wb_data), .wb_mask(wb_mask),
      .occupancy(occupancy), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] exp_mask(input logic [7:0] m);
      return MASK_EN ? m : 8'hFF;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [4:0] r, input logic [127:0] d, input logic [7:0] m, input logic w);
      stage_t e;
      in_valid = 1'b1; in_wen = w; in_wreg = r; in_data = d; in_mask = m;
      if (w && !stall && !flush) begin
         e.valid = 1'b1; e.wen = 1'b1; e.wreg = r; e.mask = m; e.data = d;
         exp_q.push_back(e);
      end
      step();
      in_valid = 1'b0; in_wen = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      exp_q.delete();
      reset = 1'b0;
   endtask

   // Writeback monitor: each commit must match the oldest expected entry.
   always @(negedge clk) begin : monitor
      stage_t e;
      if (!reset && wb_fire) begin
         if (exp_q.size() == 0) chk("wb_spurious", wb_fire, 1'b0);
         else begin
            e = exp_q.pop_front();
            chk("wb_reg", wb_reg, e.wreg);
            chk("wb_data", wb_data, e.data);
            chk("wb_mask", wb_mask, exp_mask(e.mask));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; in_valid = 0; in_wen = 0; in_wreg = 0; in_data = 0; in_mask = 0;
      stall = 0; flush = 0; rs_a = 0; rs_b = 0; rf_a = 0; rf_b = 0;
      #3;
      chk("rst_occ", occupancy, 0);
      chk("rst_stall_cycles", stall_cycles, 0);
      chk("rst_wb_fire", wb_fire, 0);
      chk("rst_wb_reg", wb_reg, 0);
      chk("rst_wb_data", wb_data, 0);
      chk("rst_wb_mask", wb_mask, exp_mask(8'h00));
      chk("rst_in_ready", in_ready, 1);
      do_reset();

      // Latency: issue -> stage 2 after three edges
      issue(5'd4, 128'h1234, 8'hFF, 1'b1);
      chk("lat_occ1", occupancy, 1); chk("lat_fire1", wb_fire, 0);
      step();
      chk("lat_occ2", occupancy, 1); chk("lat_fire2", wb_fire, 0);
      step();
      chk("lat_occ3", occupancy, 1); chk("lat_fire3", wb_fire, 1);
      chk("lat_reg", wb_reg, 5'd4); chk("lat_data", wb_data[15:0], 16'h1234);
      step();
      chk("lat_occ4", occupancy, 0); chk("lat_fire4", wb_fire, 0);

      // Priority: youngest writer wins; miss on port b
      issue(5'd7, {8{16'hAAAA}}, 8'hFF, 1'b1);
      issue(5'd7, {8{16'h5555}}, 8'hFF, 1'b1);
      rs_a = 5'd7; rf_a = {8{16'h0F0F}}; rs_b = 5'd9; rf_b = {8{16'hC3C3}};
      #1;
      chk("prio_a0", fwd_a, {8{16'h5555}}); chk("prio_hit0", fwd_hit_a, 8'hFF);
      chk("miss_b", fwd_b, {8{16'hC3C3}});  chk("miss_hit_b", fwd_hit_b, 8'h00);
      step();
      chk("prio_a1", fwd_a, {8{16'h5555}}); chk("prio_hit1", fwd_hit_a, 8'hFF);
      step();
      chk("prio_a2", fwd_a, {8{16'h5555}});
      step();
      chk("prio_drained", fwd_a, {8{16'h0F0F}}); chk("prio_drained_hit", fwd_hit_a, 8'h00);

      // Matching entry with wen=0 never forwards or commits
      issue(5'd3, {8{16'h1357}}, 8'hFF, 1'b0);
      rs_a = 5'd3; #1;
      chk("nowen_fwd", fwd_a, {8{16'h0F0F}}); chk("nowen_hit", fwd_hit_a, 8'h00);
      chk("nowen_occ", occupancy, 1);
      step(); step(); step();

      // Lane merge between an older full-mask and a younger partial-mask writer
      issue(5'd2, {8{16'h1111}}, 8'hFF, 1'b1);
      issue(5'd2, {8{16'h2222}}, 8'h0F, 1'b1);
      rs_a = 5'd2; rf_a = {8{16'h9999}}; #1;
      chk("merge_fwd", fwd_a, MASK_EN ? {{4{16'h1111}}, {4{16'h2222}}} : {8{16'h2222}});
      chk("merge_hit", fwd_hit_a, 8'hFF);
      step(); step(); step();

      // Mask=0 entry still commits
      issue(5'd5, {8{16'h0BEE}}, 8'h00, 1'b1);
      rs_a = 5'd5; rf_a = {8{16'h7777}}; #1;
      chk("mask0_fwd", fwd_a, MASK_EN ? {8{16'h7777}} : {8{16'h0BEE}});
      chk("mask0_hit", fwd_hit_a, MASK_EN ? 8'h00 : 8'hFF);
      step(); step(); step();
      chk("drain1", exp_q.size(), 0);

      // Stall + flush: stage 0 killed, later stages held, no commit while stalled
      do_reset();
      issue(5'd10, {8{16'hA0A0}}, 8'hFF, 1'b1);
      issue(5'd11, {8{16'hB1B1}}, 8'hFF, 1'b1);
      issue(5'd12, {8{16'hC2C2}}, 8'hFF, 1'b1);
      stall = 1'b1; flush = 1'b1; #1;
      void'(exp_q.pop_back());
      chk("sf_fire_held", wb_fire, 0); chk("sf_ready", in_ready, 0);
      step();
      stall = 1'b0; flush = 1'b0;
      rs_a = 5'd12; #1;
      chk("sf_occ", occupancy, 2); chk("sf_stall_cycles", stall_cycles, 1);
      chk("sf_killed_hit", fwd_hit_a, 8'h00);
      chk("sf_fire_a", wb_fire, 1); chk("sf_reg_a", wb_reg, 5'd10);
      step();
      chk("sf_fire_b", wb_fire, 1); chk("sf_reg_b", wb_reg, 5'd11);
      step();
      chk("sf_bubble", wb_fire, 0);
      step();
      chk("sf_empty", occupancy, 0);
      stall = 1'b1; step(); step(); stall = 1'b0;
      chk("stall_empty_no_count", stall_cycles, 1);

      // Reset mid-flight discards everything
      issue(5'd20, {8{16'h2020}}, 8'hFF, 1'b1);
      issue(5'd21, {8{16'h2121}}, 8'hFF, 1'b1);
      issue(5'd22, {8{16'h2222}}, 8'hFF, 1'b1);
      chk("mid_occ_full", occupancy, 3);
      #2 reset = 1'b1;
      #1;
      chk("mid_rst_occ", occupancy, 0); chk("mid_rst_fire", wb_fire, 0);
      chk("mid_rst_stall_cycles", stall_cycles, 0);
      exp_q.delete();
      step();
      reset = 1'b0;
      step(); step(); step(); step();
      chk("mid_after_occ", occupancy, 0);
      chk("drain2", exp_q.size(), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
